// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds the fetch FSM states, reset defaults and the instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 16;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;

endpackage

// File: rtl/pc_register.sv
// Program counter register: 32 bits, load enable, asynchronous
// active-low reset to RESET_PC.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RESET_PC;
    else if (en) q <= d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at PC, latches it, holds it until
// consumed, then advances PC sequentially or to a branch target.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic        InstrValid,
  output logic [31:0] PCPlus8,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_t  state, next_state;
  logic          started;
  logic [CW-1:0] timeout_cnt;
  logic [31:0]   pc, pc_next;
  logic          consume;
  logic          fetch_active;
  logic          unused_bt;

  // The request stays low until the first edge after reset release.
  assign fetch_active = (state == FETCH) && started;
  assign unused_bt    = ^BranchTarget[1:0];

  assign pc_next   = PCSrc ? {BranchTarget[31:2], 2'b00} : pc + 32'd4;
  assign imem_addr = pc;
  assign PCPlus8   = pc + 32'd8;

  assign Cond  = Instr[COND_MSB:COND_LSB];
  assign Op    = Instr[OP_MSB:OP_LSB];
  assign Funct = Instr[FUNCT_MSB:FUNCT_LSB];

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (consume),
    .d   (pc_next),
    .q   (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      started <= 1'b0;
    end else begin
      state   <= next_state;
      started <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    InstrValid = 1'b0;
    fetch_err  = 1'b0;
    consume    = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = started;
        if (started) begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (imem_ack)                     next_state = HOLD;
          else if (timeout_cnt == CNT_LAST) next_state = ERROR;
        end
      end
      HOLD: begin
        InstrValid = 1'b1;
        if (!stall) begin
          consume    = 1'b1;
          next_state = FETCH;
        end
      end
      ERROR: fetch_err = 1'b1;
      default: next_state = ERROR;
    endcase
  end

  // Counter is zero whenever outside a waiting FETCH, so entry always clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           timeout_cnt <= '0;
    else if (fetch_active && !imem_ack) timeout_cnt <= timeout_cnt + 1'b1;
    else                                timeout_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          Instr <= '0;
    else if (fetch_active && imem_ack) Instr <= imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed corner cases plus random
// fetch/hold traffic, with a scoreboard monitor on each newly valid instruction.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, PCSrc, imem_ack, imem_req, InstrValid, fetch_err;
  logic [31:0] BranchTarget, imem_addr, imem_rdata, Instr, PCPlus8;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .Instr        (Instr),
    .Cond         (Cond),
    .Op           (Op),
    .Funct        (Funct),
    .InstrValid   (InstrValid),
    .PCPlus8      (PCPlus8),
    .fetch_err    (fetch_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at a falling edge with the DUT requesting; ack arrives after 'waits' idle cycles.
  task automatic do_fetch(input int waits, input logic [31:0] word);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req", imem_req, 1'b1);
      check("fetch_addr", imem_addr, model_pc);
      check("fetch_valid", InstrValid, 1'b0);
      check("fetch_err_low", fetch_err, 1'b0);
      stall        = 1'($urandom);
      PCSrc        = 1'($urandom);
      BranchTarget = $urandom;
      imem_ack     = (i == waits);
      imem_rdata   = (i == waits) ? word : $urandom;
      if (i == waits) begin
        e.instr = word;
        e.pc    = model_pc;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  // Called at a falling edge with an instruction held; consumes after 'stalls' cycles.
  task automatic do_hold(input int stalls, input logic src, input logic [31:0] bt);
    for (int i = 0; i <= stalls; i++) begin
      check("hold_req", imem_req, 1'b0);
      check("hold_valid", InstrValid, 1'b1);
      check("hold_addr", imem_addr, model_pc);
      check("hold_pcplus8", PCPlus8, model_pc + 32'd8);
      stall        = (i < stalls);
      PCSrc        = (i < stalls) ? 1'($urandom) : src;
      BranchTarget = (i < stalls) ? $urandom : bt;
      imem_ack     = 1'($urandom);
      imem_rdata   = $urandom;
      @(negedge clk);
    end
    model_pc = src ? {bt[31:2], 2'b00} : model_pc + 32'd4;
    imem_ack = 1'b0;
    stall    = 1'b0;
    check("consume_valid_low", InstrValid, 1'b0);
  endtask

  // Scoreboard monitor: compares each newly presented instruction and its hold.
  initial begin : monitor
    logic  prev_valid;
    exp_t  e;
    logic [31:0] held;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (InstrValid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr got %h expected none", Instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", Instr, e.instr);
          check("cond", 32'(Cond), 32'(e.instr[31:28]));
          check("op", 32'(Op), 32'(e.instr[27:26]));
          check("funct", 32'(Funct), 32'(e.instr[25:20]));
          check("pcplus8_mon", PCPlus8, e.pc + 32'd8);
          held = e.instr;
        end
      end else if (InstrValid === 1'b1 && prev_valid) begin
        check("instr_held", Instr, held);
      end
      prev_valid = InstrValid;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not terminate");
  end

  initial begin : driver
    rst = 1'b0; stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    imem_ack = 1'b0; imem_rdata = '0; model_pc = RST_PC;

    // Held in reset: ack traffic must not leak through.
    repeat (3) begin
      @(negedge clk);
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", InstrValid, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      check("rst_instr", Instr, 32'h0);
      check("rst_addr", imem_addr, RST_PC);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
    end
    imem_ack = 1'b0;
    rst = 1'b1;
    #1 check("req_before_first_edge", imem_req, 1'b0);
    @(negedge clk);

    // Sequential fetch with immediate ack: 0,4,8,C.
    for (int k = 0; k < 4; k++) begin
      check("seq_addr", imem_addr, RST_PC + 32'(4 * k));
      do_fetch(0, $urandom);
      do_hold(0, 1'b0, $urandom);
    end

    // Stall five cycles, then branch to 0x43 -> fetch at 0x40.
    do_fetch(0, $urandom);
    do_hold(5, 1'b1, 32'h0000_0043);
    check("branch_addr", imem_addr, 32'h0000_0040);

    // Ack delayed three cycles.
    do_fetch(3, 32'hA5C3_F00D);
    do_hold(0, 1'b0, $urandom);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      do_fetch($urandom_range(0, 6), $urandom);
      do_hold($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom);
    end

    // Wrap at the top of the address space.
    do_fetch(0, $urandom);
    do_hold(1, 1'b1, 32'hFFFF_FFFE);
    check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(0, $urandom);
    do_hold(0, 1'b0, $urandom);
    check("wrap_zero_addr", imem_addr, 32'h0000_0000);

    // Ack in the last allowed cycle is accepted.
    do_fetch(TMO - 1, 32'h1234_5678);
    check("late_ack_no_err", fetch_err, 1'b0);
    do_hold(0, 1'b1, 32'h0000_0100);

    // Reset while holding, with an ack pulse during reset.
    do_fetch(0, $urandom);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rst_hold_valid", InstrValid, 1'b0);
    check("rst_hold_addr", imem_addr, RST_PC);
    @(negedge clk);
    check("rst_hold_instr", Instr, 32'h0);
    check("rst_hold_req", imem_req, 1'b0);
    imem_ack = 1'b0;
    rst      = 1'b1;
    model_pc = RST_PC;
    @(negedge clk);

    do_fetch(1, $urandom);
    do_hold(0, 1'b0, $urandom);

    // No ack at all: error after TMO fetch cycles, sticky afterwards.
    for (int i = 0; i < int'(TMO); i++) begin
      check("to_req", imem_req, 1'b1);
      check("to_err_low", fetch_err, 1'b0);
      check("to_addr", imem_addr, model_pc);
      imem_ack = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check("err_set", fetch_err, 1'b1);
      check("err_req", imem_req, 1'b0);
      check("err_valid", InstrValid, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      stall      = 1'b0;
      @(negedge clk);
    end
    imem_ack = 1'b0;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
